div_seq_unit: RTL and testbench

- Multi-cycle sequencer for the integer divide resource used by the execute stage for DIV/DIVU/REM/REMU.
- Accepts one operation through a valid/ready request port and runs a radix-2 restoring divide, one quotient bit per cycle.
- Applies the RISC-V corner-case rules and returns the result through a valid/ready response port.
- The execute stage stalls on busy and kills in-flight work with flush on a branch redirect.

---
 rtl/div_seq_unit_pkg.sv | 32 +++
 rtl/div_seq_unit_step.sv | 31 +++
 rtl/div_seq_unit.sv | 144 ++++++++++++++
 tb/tb_div_seq_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/div_seq_unit_pkg.sv
// Shared definitions for the sequential integer divide unit: op encoding,
// FSM state encoding and the default datapath width.
package div_seq_unit_pkg;

    localparam int unsigned DIV_XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        DIV_IDLE,
        DIV_PREP,
        DIV_CALC,
        DIV_FIX,
        DIV_DONE
    } div_state_e;

    // DIV and REM treat operands as two's complement
    function automatic logic div_is_signed(input div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    // REM and REMU return the remainder instead of the quotient
    function automatic logic div_is_rem(input div_op_e op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_seq_unit_step.sv
// One radix-2 restoring divide iteration, purely combinational.
// The dividend register shifts its MSB into the partial remainder and
// receives the new quotient bit in its LSB.
module div_step
    import div_seq_unit_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] dvd,
    input  logic [XLEN-1:0] dsr,
    output logic [XLEN:0]   next_rem,
    output logic [XLEN-1:0] next_dvd
);

    logic [XLEN+1:0] shifted;
    logic [XLEN:0]   dsr_ext;
    logic [XLEN:0]   diff;
    logic            ge;

    // shift, trial-subtract, restore when the subtraction would go negative
    always_comb begin
        shifted  = {rem, dvd[XLEN-1]};
        dsr_ext  = {1'b0, dsr};
        ge       = (shifted >= {1'b0, dsr_ext});
        diff     = shifted[XLEN:0] - dsr_ext;
        next_rem = ge ? diff : shifted[XLEN:0];
        next_dvd = {dvd[XLEN-2:0], ge};
    end

endmodule

// File: rtl/div_seq_unit.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer for the execute stage.
// Request/response valid/ready handshakes, RISC-V divide-by-zero and
// signed-overflow results resolved at acceptance, flush aborts any work.
module div_seq_unit
    import div_seq_unit_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_vld,
    output logic            req_rdy,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_opa,
    input  logic [XLEN-1:0] req_opb,
    output logic            rsp_vld,
    input  logic            rsp_rdy,
    output logic [XLEN-1:0] rsp_data,
    output logic            busy
);

    localparam int unsigned     CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state;
    div_op_e         op_q;
    logic            sgn_q;
    logic            neg_q;
    logic            neg_r;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dsr;

    div_op_e         req_op_e;
    logic            req_sgn;
    logic            req_is_rem;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN-1:0] dsr_mag;
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_dvd;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign req_rdy = (state == DIV_IDLE) && !flush;
    assign busy    = (state != DIV_IDLE);

    // decode the incoming op and the operand magnitudes / sign-fixed results
    always_comb begin
        req_op_e   = div_op_e'(req_op);
        req_sgn    = div_is_signed(req_op_e);
        req_is_rem = div_is_rem(req_op_e);
        dvd_mag    = (sgn_q && dvd[XLEN-1]) ? ('0 - dvd) : dvd;
        dsr_mag    = (sgn_q && dsr[XLEN-1]) ? ('0 - dsr) : dsr;
        q_fix      = neg_q ? ('0 - dvd) : dvd;
        r_fix      = neg_r ? ('0 - rem[XLEN-1:0]) : rem[XLEN-1:0];
    end

    div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem      (rem),
        .dvd      (dvd),
        .dsr      (dsr),
        .next_rem (step_rem),
        .next_dvd (step_dvd)
    );

    // sequencer: accept, prepare magnitudes, iterate, fix signs, hand off
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= DIV_IDLE;
            op_q     <= DIV_OP_DIV;
            sgn_q    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            rsp_vld  <= 1'b0;
            rsp_data <= '0;
        end else if (flush) begin
            state   <= DIV_IDLE;
            rsp_vld <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (req_vld) begin
                        op_q  <= req_op_e;
                        sgn_q <= req_sgn;
                        dvd   <= req_opa;
                        dsr   <= req_opb;
                        if (req_opb == '0) begin
                            state    <= DIV_DONE;
                            rsp_vld  <= 1'b1;
                            rsp_data <= req_is_rem ? req_opa : '1;
                        end else if (req_sgn && (req_opa == INT_MIN) && (req_opb == '1)) begin
                            state    <= DIV_DONE;
                            rsp_vld  <= 1'b1;
                            rsp_data <= req_is_rem ? '0 : req_opa;
                        end else begin
                            state <= DIV_PREP;
                        end
                    end
                end
                DIV_PREP: begin
                    dvd   <= dvd_mag;
                    dsr   <= dsr_mag;
                    neg_q <= sgn_q && (dvd[XLEN-1] != dsr[XLEN-1]);
                    neg_r <= sgn_q && dvd[XLEN-1];
                    rem   <= '0;
                    cnt   <= CW'(XLEN - 1);
                    state <= DIV_CALC;
                end
                DIV_CALC: begin
                    rem <= step_rem;
                    dvd <= step_dvd;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    rsp_data <= div_is_rem(op_q) ? r_fix : q_fix;
                    rsp_vld  <= 1'b1;
                    state    <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        state   <= DIV_IDLE;
                    end
                end
                default: begin
                    state   <= DIV_IDLE;
                    rsp_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_unit.sv
// Directed self-checking bench for div_seq_unit (XLEN=32).
module tb_div_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_vld;
    logic        req_rdy;
    logic [1:0]  req_op;
    logic [31:0] req_opa;
    logic [31:0] req_opb;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_data;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;
    logic busy_ok;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    div_seq_unit #(
        .XLEN (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_op   (req_op),
        .req_opa  (req_opa),
        .req_opb  (req_opb),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_data (rsp_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // present a request on a negedge, drop it after the accepting edge and
    // scramble the operands to show they were captured
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_op  = op;
        req_opa = a;
        req_opb = b;
        req_vld = 1'b1;
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        req_opa = ~a;
        req_opb = ~b;
    endtask

    // count cycles from the accepting edge (inclusive) to rsp_vld, bounded
    task automatic wait_rsp(output int lat);
        lat     = 1;
        busy_ok = 1'b1;
        while (!rsp_vld && lat < 100) begin
            if (!busy || req_rdy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        send(op, a, b);
        wait_rsp(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check(tag, rsp_data, exp);
        check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_ack"}, {31'd0, rsp_vld}, 32'd0);
    endtask

    initial begin
        int lat;
        logic seen;
        rst     = 1'b0;
        flush   = 1'b0;
        req_vld = 1'b0;
        req_op  = '0;
        req_opa = '0;
        req_opb = '0;
        rsp_rdy = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_vld",  {31'd0, rsp_vld}, 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdy",  {31'd0, req_rdy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // normal path, unsigned and signed
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 35);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 35);
        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
        run_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 35);
        run_op("div_min_1",  OP_DIV,  32'h8000_0000, 32'd1, 32'h8000_0000, 35);
        run_op("div_0_5",    OP_DIV,  32'd0, 32'd5, 32'd0, 35);
        run_op("divu_x_1",   OP_DIVU, 32'd12345, 32'd1, 32'd12345, 35);

        // special cases resolved at acceptance
        run_op("divu_5_0",   OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0",   OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("rem_m5_0",   OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // response held while the consumer stalls
        rsp_rdy = 1'b0;
        send(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
        wait_rsp(lat);
        check("hold_lat", 32'(lat), 32'd35);
        check("hold_data0", rsp_data, 32'h5555_5555);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_vld",  {31'd0, rsp_vld}, 32'd1);
            check("hold_data", rsp_data, 32'h5555_5555);
            check("hold_rdy",  {31'd0, req_rdy}, 32'd0);
        end
        @(negedge clk);
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("hold_rel_vld",  {31'd0, rsp_vld}, 32'd0);
        check("hold_rel_rdy",  {31'd0, req_rdy}, 32'd1);
        check("hold_rel_busy", {31'd0, busy}, 32'd0);

        // flush during CALC with a competing request
        send(OP_DIVU, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush   = 1'b1;
        req_vld = 1'b1;
        req_op  = OP_DIVU;
        req_opa = 32'd50;
        req_opb = 32'd5;
        #1;
        check("flush_rdy", {31'd0, req_rdy}, 32'd0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        req_vld = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_vld",  {31'd0, rsp_vld}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            seen = seen | rsp_vld | busy;
        end
        check("flush_quiet", {31'd0, seen}, 32'd0);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 35);

        // reset in the middle of CALC
        send(OP_DIVU, 32'd100, 32'd7);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_vld",  {31'd0, rsp_vld}, 32'd0);
        check("mrst_data", rsp_data, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_rdy", {31'd0, req_rdy}, 32'd1);
        run_op("remu_10_4", OP_REMU, 32'd10, 32'd4, 32'd2, 35);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
